// File: rtl/fir_mac_engine.sv
// rtl/fir_mac_engine.sv - time-multiplexed FIR filter with lane-parallel MAC and round/shift/saturate output
module fir_mac_engine #(
  parameter int NUM_TAPS  = 40,
  parameter int LANES     = 4,
  parameter int DIN_W     = 3,
  parameter int COEF_W    = 16,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 0
) (
  input  logic                        iClk12M,
  input  logic                        iRst,
  input  logic                        iEnSample600k,
  input  logic                        iCoeffUpdateFlag,
  input  logic                        iCoeffWrEn,
  input  logic [$clog2(NUM_TAPS)-1:0] iCoeffAddr,
  input  logic signed [COEF_W-1:0]    iCoeffWrDt,
  input  logic [$clog2(NUM_TAPS):0]   iNumOfCoeff,
  input  logic signed [DIN_W-1:0]     iFirIn,
  input  logic                        iClrOverrun,
  output logic signed [OUT_W-1:0]     oFirOut,
  output logic                        oValid,
  output logic                        oBusy,
  output logic                        oOverrun
);

  localparam int AW     = $clog2(NUM_TAPS);
  localparam int ACC_W  = DIN_W + COEF_W + AW;
  localparam int PROD_W = DIN_W + COEF_W;
  localparam int SW     = $clog2(NUM_TAPS / LANES + 1);
  localparam logic signed [ACC_W:0] RND =
    (ACC_W+1)'((OUT_SHIFT > 0) ? (longint'(1) <<< ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : longint'(0));
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((longint'(1) <<< (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(longint'(1) <<< (OUT_W - 1)));

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                   state;
  logic signed [DIN_W-1:0]  taps  [NUM_TAPS];
  logic signed [COEF_W-1:0] coefs [NUM_TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  lane_sum;
  logic [AW:0]              n_act;
  logic [AW:0]              n_req;
  logic [SW-1:0]            step;
  int                       steps_total;
  logic signed [ACC_W:0]    rounded;
  logic signed [ACC_W:0]    shifted;
  logic signed [OUT_W-1:0]  sat_out;

  always_comb n_req = (int'(iNumOfCoeff) > NUM_TAPS) ? (AW+1)'(NUM_TAPS) : iNumOfCoeff;
  always_comb steps_total = (int'(n_act) + LANES - 1) / LANES;

  // Taps at or beyond the latched count contribute nothing, so a partial last step is harmless.
  always_comb begin
    int                      idx;
    logic [AW-1:0]           ia;
    logic signed [PROD_W-1:0] prod;
    lane_sum = '0;
    idx      = 0;
    ia       = '0;
    prod     = '0;
    for (int l = 0; l < LANES; l++) begin
      idx = int'(step) * LANES + l;
      if (idx < int'(n_act)) begin
        ia       = AW'(idx);
        prod     = PROD_W'(coefs[ia]) * PROD_W'(taps[ia]);
        lane_sum = lane_sum + ACC_W'(prod);
      end
    end
  end

  always_comb begin
    rounded = {acc[ACC_W-1], acc} + RND;
    shifted = rounded >>> OUT_SHIFT;
    if (shifted > SAT_MAX) begin
      sat_out = SAT_MAX[OUT_W-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_out = SAT_MIN[OUT_W-1:0];
    end else begin
      sat_out = shifted[OUT_W-1:0];
    end
  end

  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state    <= IDLE;
      acc      <= '0;
      n_act    <= '0;
      step     <= '0;
      oFirOut  <= '0;
      oValid   <= 1'b0;
      oBusy    <= 1'b0;
      oOverrun <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        taps[i]  <= '0;
        coefs[i] <= '0;
      end
    end else begin
      oValid <= 1'b0;
      if (iCoeffUpdateFlag && iCoeffWrEn && int'(iCoeffAddr) < NUM_TAPS) begin
        coefs[iCoeffAddr] <= iCoeffWrDt;
      end
      // A dropped strobe outranks a clear in the same cycle.
      if (iEnSample600k && oBusy) begin
        oOverrun <= 1'b1;
      end else if (iClrOverrun) begin
        oOverrun <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (iEnSample600k) begin
            for (int i = NUM_TAPS - 1; i > 0; i--) begin
              taps[i] <= taps[i-1];
            end
            taps[0] <= iFirIn;
            if (!iCoeffUpdateFlag) begin
              acc   <= '0;
              n_act <= n_req;
              step  <= '0;
              oBusy <= 1'b1;
              state <= (n_req != '0) ? MAC : OUT;
            end
          end
        end
        MAC: begin
          if (iCoeffUpdateFlag) begin
            state <= IDLE;
            oBusy <= 1'b0;
          end else begin
            acc  <= acc + lane_sum;
            step <= step + SW'(1);
            if (int'(step) + 1 >= steps_total) begin
              state <= OUT;
            end
          end
        end
        OUT: begin
          state <= IDLE;
          oBusy <= 1'b0;
          if (!iCoeffUpdateFlag) begin
            oFirOut <= sat_out;
            oValid  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// tb/tb_fir_mac_engine.sv - scoreboard bench for fir_mac_engine (default and OUT_SHIFT=4 instances)
module tb_fir_mac_engine;

  localparam int NT = 40;

  logic clk = 1'b0;
  logic rst, stb, upd, wr_en, clr;
  logic [5:0] addr;
  logic signed [15:0] wdat;
  logic [6:0] ncoef;
  logic signed [2:0] din;
  logic signed [15:0] out_m, out_s;
  logic val_m, val_s, busy_m, busy_s, ovr_m, ovr_s;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  longint mtap [NT];
  longint mcoef [NT];
  longint last_main = 0;

  typedef struct {
    longint val;
    int     due;
  } exp_t;
  exp_t qm[$];
  exp_t qs[$];

  fir_mac_engine dut (
    .iClk12M(clk), .iRst(rst), .iEnSample600k(stb), .iCoeffUpdateFlag(upd),
    .iCoeffWrEn(wr_en), .iCoeffAddr(addr), .iCoeffWrDt(wdat), .iNumOfCoeff(ncoef),
    .iFirIn(din), .iClrOverrun(clr), .oFirOut(out_m), .oValid(val_m),
    .oBusy(busy_m), .oOverrun(ovr_m)
  );

  fir_mac_engine #(.OUT_SHIFT(4)) dut_sh (
    .iClk12M(clk), .iRst(rst), .iEnSample600k(stb), .iCoeffUpdateFlag(upd),
    .iCoeffWrEn(wr_en), .iCoeffAddr(addr), .iCoeffWrDt(wdat), .iNumOfCoeff(ncoef),
    .iFirIn(din), .iClrOverrun(clr), .oFirOut(out_s), .oValid(val_s),
    .oBusy(busy_s), .oOverrun(ovr_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int a, input int v, input bit mdl);
    addr  = 6'(a);
    wdat  = 16'(v);
    wr_en = 1'b1;
    if (mdl) mcoef[a] = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_ramp();
    upd = 1'b1;
    for (int k = 0; k < NT; k++) wr(k, k + 1, 1'b1);
    upd = 1'b0;
    @(negedge clk);
  endtask

  // Caller sits at a negedge; the strobe is sampled on the following posedge.
  task automatic strobe(input int x, input bit shift, input bit push);
    longint y;
    int n, s;
    exp_t e;
    din = 3'(x);
    stb = 1'b1;
    if (shift) begin
      for (int i = NT - 1; i > 0; i--) mtap[i] = mtap[i-1];
      mtap[0] = x;
    end
    if (push) begin
      n = (int'(ncoef) > NT) ? NT : int'(ncoef);
      y = 0;
      for (int k = 0; k < n; k++) y += mcoef[k] * mtap[k];
      s = (n + 3) / 4;
      e.due = cyc + s + 2;
      e.val = sat16(y);
      qm.push_back(e);
      last_main = e.val;
      e.val = sat16((y + 8) >>> 4);
      qs.push_back(e);
    end
    @(negedge clk);
    stb = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (val_m) begin
      if (qm.size() == 0) check("valid_m_unexpected", val_m, 0);
      else begin
        e = qm.pop_front();
        check("out_m", out_m, e.val);
        check("latency_m", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (val_s) begin
      if (qs.size() == 0) check("valid_s_unexpected", val_s, 0);
      else begin
        e = qs.pop_front();
        check("out_s", out_s, e.val);
        check("latency_s", cyc, e.due);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete, total=%0d", total);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stb = 1'b0; upd = 1'b0; wr_en = 1'b0; clr = 1'b0;
    addr = '0; wdat = '0; ncoef = 7'd40; din = '0;
    for (int k = 0; k < NT; k++) begin mtap[k] = 0; mcoef[k] = 0; end
    gap(3);
    check("rst_out", out_m, 0);
    check("rst_valid", val_m, 0);
    check("rst_busy", busy_m, 0);
    check("rst_ovr", ovr_m, 0);
    rst = 1'b0;
    gap(1);

    // Impulse response over all 40 taps
    load_ramp();
    strobe(1, 1'b1, 1'b1);
    check("busy_in_mac", busy_m, 1);
    gap(12);
    for (int i = 0; i < NT; i++) begin strobe(0, 1'b1, 1'b1); gap(12); end
    check("impulse_tail", out_m, 0);

    // Short filter, then zero taps
    ncoef = 7'd5;
    strobe(1, 1'b1, 1'b1); gap(12);
    for (int i = 0; i < 5; i++) begin strobe(0, 1'b1, 1'b1); gap(12); end
    ncoef = 7'd0;
    strobe(1, 1'b1, 1'b1); gap(12);

    // Saturation in both directions, then rounding with OUT_SHIFT=4
    upd = 1'b1;
    for (int k = 0; k < NT; k++) wr(k, 32767, 1'b1);
    upd = 1'b0;
    ncoef = 7'd40;
    gap(1);
    for (int i = 0; i < NT; i++) begin strobe(3, 1'b1, 1'b1); gap(12); end
    check("sat_pos_hand", out_m, 32767);
    for (int i = 0; i < NT; i++) begin strobe(-4, 1'b1, 1'b1); gap(12); end
    check("sat_neg_hand", out_m, -32768);
    upd = 1'b1; wr(0, 24, 1'b1); upd = 1'b0;
    ncoef = 7'd1;
    gap(1);
    strobe(1, 1'b1, 1'b1); gap(12);
    check("round_shift_hand", out_s, 2);
    check("single_tap_hand", out_m, 24);

    // Overrun: strobes 5 cycles apart while a 40-tap run is busy
    ncoef = 7'd40;
    load_ramp();
    check("ovr_init", ovr_m, 0);
    strobe(2, 1'b1, 1'b1); gap(4);
    strobe(5, 1'b0, 1'b0);
    check("ovr_set", ovr_m, 1);
    gap(4);
    strobe(7, 1'b0, 1'b0); gap(4);
    strobe(1, 1'b1, 1'b1); gap(12);
    clr = 1'b1; gap(1); clr = 1'b0;
    check("ovr_clear", ovr_m, 0);
    strobe(3, 1'b1, 1'b1); gap(1);
    strobe(6, 1'b0, 1'b0); gap(1);
    clr = 1'b1;
    strobe(4, 1'b0, 1'b0);
    clr = 1'b0;
    check("ovr_set_wins", ovr_m, 1);
    gap(12);
    clr = 1'b1; gap(1); clr = 1'b0;

    // Abort by coefficient update during MAC
    strobe(1, 1'b1, 1'b0);
    gap(3);
    upd = 1'b1;
    gap(1);
    check("abort_busy", busy_m, 0);
    check("abort_hold", out_m, last_main);
    wr(40, 1000, 1'b0);
    wr(3, 100, 1'b1);
    gap(15);
    check("abort_hold_late", out_m, last_main);
    upd = 1'b0;
    gap(1);
    strobe(1, 1'b1, 1'b1); gap(12);

    // Reset in the middle of a run
    strobe(2, 1'b1, 1'b0); gap(1);
    strobe(5, 1'b0, 1'b0);
    rst = 1'b1;
    gap(1);
    rst = 1'b0;
    check("midrst_out", out_m, 0);
    check("midrst_out_s", out_s, 0);
    check("midrst_busy", busy_m, 0);
    check("midrst_ovr", ovr_m, 0);
    check("midrst_valid", val_m, 0);
    for (int k = 0; k < NT; k++) begin mtap[k] = 0; mcoef[k] = 0; end
    load_ramp();
    strobe(1, 1'b1, 1'b1); gap(12);
    check("post_reset_hand", out_m, 1);

    gap(14);
    check("drain_m", qm.size(), 0);
    check("drain_s", qs.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
